video_ar_window: RTL and testbench
==================================

# video_ar_window

Converts the aspect-ratio / integer-size code produced by the crop and integer-scale stage (VIDEO_ARX/VIDEO_ARY) into a concrete output window inside the HDMI raster: horizontal and vertical first/last active pixel. It sits between the crop/scale stage and the output scaler/framer, on the CLK_VIDEO domain. Recalculation is automatic whenever any input changes. Each new window is committed atomically with a one-cycle strobe.

## Interface
- DIV_W, 24: divider numerator/quotient width; the denominator is fixed at 12 bits.
- CLK_VIDEO  in  1  video clock.
- RESET_N  in  1  asynchronous, active-low reset.
- HDMI_WIDTH  in  12  output raster width in pixels.
- HDMI_HEIGHT  in  12  output raster height in lines.
- VIDEO_ARX  in  13  bit12=1: absolute width in [11:0]; bit12=0: aspect X.
- VIDEO_ARY  in  13  bit12=1: absolute height in [11:0]; bit12=0: aspect Y.
- HMIN, HMAX  out  12  first/last active column.
- VMIN, VMAX  out  12  first/last active line.
- WIN_VALID  out  1  one-cycle pulse when HMIN..VMAX update.
- BUSY  out  1  high while a calculation is in progress.

## Operation
- Reset values: all window outputs 0, WIN_VALID=0, BUSY=0. A calculation is forced on the first cycle after reset release.
- Shadow registers hold the last-latched copy of all four inputs. In IDLE, any mismatch (or the forced start) latches the inputs, sets BUSY and leaves IDLE.
- FSM states: IDLE, MUL1, DIV1, CHECK, MUL2, DIV2, SIZE, PLACE, COMMIT.
- Absolute mode (both bit12 set): IDLE→SIZE→PLACE→COMMIT.
  - w = min(ARX[11:0], HDMI_WIDTH); h = min(ARY[11:0], HDMI_HEIGHT).
  - A zero component means full dimension.
- Mixed flags (exactly one bit12 set), ARX[11:0]=0 or ARY[11:0]=0: full screen via SIZE.
- Ratio mode:
  - MUL1: p = HDMI_HEIGHT*ARX (24 b).
  - DIV1: wt = p/ARY (floor).
  - CHECK: if wt ≤ HDMI_WIDTH, then w=wt, h=HDMI_HEIGHT → PLACE.
  - Otherwise MUL2: HDMI_WIDTH*ARY; DIV2: h = that/ARX (floor); w=HDMI_WIDTH.
  - Quotient bits above [11:0] are treated as overflow (CHECK takes the else path).
- Clamp w and h to a minimum of 1.
- PLACE:
  - HMIN=(HDMI_WIDTH−w)>>1; HMAX=HMIN+w−1.
  - VMIN=(HDMI_HEIGHT−h)>>1; VMAX=VMIN+h−1.
  - All arithmetic is unsigned, 12 b.
- COMMIT: write all four outputs in the same cycle, pulse WIN_VALID, clear BUSY, return to IDLE.
- Input change while BUSY: abort at the next edge, re-latch, restart from the mode decision. No WIN_VALID is issued for the abandoned set. The divider is restarted, not drained.
- If the recalculated window equals the current one, WIN_VALID still pulses.
- Asynchronous reset mid-calculation: everything returns to reset values; the forced start repeats.

## Timing
- Cycle 0 is the edge at which the changed input is sampled into IDLE's comparison.
- Divider latency: quotient valid, with DONE asserted, exactly 24 cycles after its START cycle.
- Absolute / full-screen path: WIN_VALID is asserted in cycle 4.
- Ratio path, fits: MUL1 at cycle 1, DIV1 START at cycle 2, DONE at 26, CHECK at 27, PLACE at 28, COMMIT at 29; WIN_VALID at cycle 30.
- Ratio path, overflow: MUL2 at 28, DIV2 START at 29, DONE at 53, PLACE at 54, COMMIT at 55; WIN_VALID at cycle 56.
- Outputs are registered and stable except in the single COMMIT update cycle.

## Structure
- Shared package video_pkg:
  - FSM state enum.
  - ABS_FLAG bit index (12).
  - Coordinate width constant (12).
- One sub-module, video_ar_div: restoring radix-2 divider.
  - Ports: START, NUM[DIV_W], DEN[12], QUO[DIV_W], DONE, same clock and reset.
  - Divide by zero returns all-ones. The FSM never issues it.
- The multiplier is a single-cycle registered `*`, kept in the top level.

## Test plan
- 1920×1080, ARX=4, ARY=3 → HMIN=240, HMAX=1679, VMIN=0, VMAX=1079, WIN_VALID at cycle 30.
- 1920×1080, ARX=21, ARY=9 → h=822, HMIN=0, HMAX=1919, VMIN=129, VMAX=950, WIN_VALID at cycle 56.
- 1920×1080, ARX=0x1500 (abs 1280), ARY=0x13C0 (abs 960) → HMIN=320, HMAX=1599, VMIN=60, VMAX=1019, WIN_VALID at cycle 4.
- ARY=0 or mixed flags → full screen 0/1919/0/1079.
- Change ARX 4→16 (ARY=3, then ARY=9) during DIV1 → exactly one WIN_VALID, carrying the 16:9 full-screen result.
- Assert RESET_N low during DIV2 → outputs 0, BUSY=0. After release, recalculation completes with correct values.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants and FSM state encoding for the aspect-ratio window calculator.
package video_pkg;
  localparam int ABS_FLAG = 12;
  localparam int COORD_W  = 12;

  typedef enum logic [3:0] {
    IDLE,
    MUL1,
    DIV1,
    CHECK,
    MUL2,
    DIV2,
    SIZE,
    PLACE,
    COMMIT
  } ar_state_t;
endpackage

// File: rtl/video_ar_window_if.sv
// Configuration inputs and committed window outputs of video_ar_window.
interface video_ar_window_if;
  logic [video_pkg::COORD_W-1:0] HDMI_WIDTH;
  logic [video_pkg::COORD_W-1:0] HDMI_HEIGHT;
  logic [video_pkg::COORD_W:0]   VIDEO_ARX;
  logic [video_pkg::COORD_W:0]   VIDEO_ARY;
  logic [video_pkg::COORD_W-1:0] HMIN;
  logic [video_pkg::COORD_W-1:0] HMAX;
  logic [video_pkg::COORD_W-1:0] VMIN;
  logic [video_pkg::COORD_W-1:0] VMAX;
  logic                          WIN_VALID;
  logic                          BUSY;

  modport master (
    output HDMI_WIDTH, HDMI_HEIGHT, VIDEO_ARX, VIDEO_ARY,
    input  HMIN, HMAX, VMIN, VMAX, WIN_VALID, BUSY
  );

  modport slave (
    input  HDMI_WIDTH, HDMI_HEIGHT, VIDEO_ARX, VIDEO_ARY,
    output HMIN, HMAX, VMIN, VMAX, WIN_VALID, BUSY
  );
endinterface

// File: rtl/video_ar_div.sv
// Restoring radix-2 divider, one quotient bit per cycle; START restarts any run in flight.
module video_ar_div
  import video_pkg::*;
#(
  parameter int DIV_W = 24
) (
  input  logic               CLK_VIDEO,
  input  logic               RESET_N,
  input  logic               START,
  input  logic [DIV_W-1:0]   NUM,
  input  logic [COORD_W-1:0] DEN,
  output logic [DIV_W-1:0]   QUO,
  output logic               DONE
);
  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [COORD_W-1:0] rem_q;
  logic [COORD_W-1:0] den_q;
  logic [DIV_W-1:0]   sr_q;
  logic [CNT_W-1:0]   cnt;
  logic               running;

  logic [COORD_W-1:0] rem_src;
  logic [COORD_W-1:0] den_src;
  logic [DIV_W-1:0]   sr_src;
  logic [COORD_W:0]   trial;
  logic [COORD_W:0]   diff;
  logic               ge;
  logic [COORD_W-1:0] rem_nxt;
  logic [DIV_W-1:0]   sr_nxt;

  // The first bit is resolved in the START cycle itself, so 24 bits finish 24 cycles later.
  always_comb begin
    rem_src = START ? '0 : rem_q;
    sr_src  = START ? NUM : sr_q;
    den_src = START ? DEN : den_q;
    trial   = {rem_src, sr_src[DIV_W-1]};
    diff    = trial - {1'b0, den_src};
    ge      = (trial >= {1'b0, den_src});
    rem_nxt = ge ? diff[COORD_W-1:0] : trial[COORD_W-1:0];
    sr_nxt  = {sr_src[DIV_W-2:0], ge};
  end

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      running <= 1'b0;
      cnt     <= '0;
      DONE    <= 1'b0;
    end else if (START) begin
      running <= 1'b1;
      cnt     <= CNT_W'(DIV_W - 1);
      DONE    <= 1'b0;
    end else if (running) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        running <= 1'b0;
        DONE    <= 1'b1;
      end
    end else begin
      DONE <= 1'b0;
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (START || running) begin
      rem_q <= rem_nxt;
      sr_q  <= sr_nxt;
    end
    if (START) den_q <= DEN;
  end

  // A zero divisor makes every trial succeed, so the quotient reads back all-ones.
  assign QUO = sr_q;
endmodule

// File: rtl/video_ar_window.sv
// Turns the aspect/absolute size code into a centred output window, committed atomically.
module video_ar_window
  import video_pkg::*;
#(
  parameter int DIV_W = 24
) (
  input  logic             CLK_VIDEO,
  input  logic             RESET_N,
  video_ar_window_if.slave bus
);
  typedef logic [COORD_W-1:0] coord_t;

  ar_state_t        state;
  ar_state_t        entry_state;
  logic             force_start;
  logic             changed;
  logic             fits;
  coord_t           sh_width;
  coord_t           sh_height;
  logic [COORD_W:0] sh_arx;
  logic [COORD_W:0] sh_ary;

  logic [DIV_W-1:0] prod;
  logic [DIV_W-1:0] quo;
  coord_t           div_den;
  logic             div_start;
  logic             div_done;

  coord_t w;
  coord_t h;
  coord_t hmin_c;
  coord_t vmin_c;
  coord_t hmin_n;
  coord_t hmax_n;
  coord_t vmin_n;
  coord_t vmax_n;

  function automatic coord_t sat_min1(input coord_t v);
    return (v == '0) ? coord_t'(1) : v;
  endfunction

  function automatic coord_t abs_size(input coord_t req, input coord_t full);
    return (req == '0 || req > full) ? full : req;
  endfunction

  always_comb begin
    changed = (bus.HDMI_WIDTH != sh_width) || (bus.HDMI_HEIGHT != sh_height) ||
              (bus.VIDEO_ARX != sh_arx) || (bus.VIDEO_ARY != sh_ary);
    // Any flag set, or a zero ratio component, bypasses the multiply/divide path.
    if (bus.VIDEO_ARX[ABS_FLAG] || bus.VIDEO_ARY[ABS_FLAG] ||
        bus.VIDEO_ARX[COORD_W-1:0] == '0 || bus.VIDEO_ARY[COORD_W-1:0] == '0)
      entry_state = SIZE;
    else
      entry_state = MUL1;
    fits    = (quo[DIV_W-1:COORD_W] == '0) && (quo[COORD_W-1:0] <= sh_width);
    div_den = (state == DIV1) ? sh_ary[COORD_W-1:0] : sh_arx[COORD_W-1:0];
    hmin_c  = (sh_width - w) >> 1;
    vmin_c  = (sh_height - h) >> 1;
  end

  video_ar_div #(.DIV_W(DIV_W)) u_div (
    .CLK_VIDEO (CLK_VIDEO),
    .RESET_N   (RESET_N),
    .START     (div_start),
    .NUM       (prod),
    .DEN       (div_den),
    .QUO       (quo),
    .DONE      (div_done)
  );

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      force_start   <= 1'b1;
      sh_width      <= '0;
      sh_height     <= '0;
      sh_arx        <= '0;
      sh_ary        <= '0;
      div_start     <= 1'b0;
      bus.HMIN      <= '0;
      bus.HMAX      <= '0;
      bus.VMIN      <= '0;
      bus.VMAX      <= '0;
      bus.WIN_VALID <= 1'b0;
      bus.BUSY      <= 1'b0;
    end else begin
      bus.WIN_VALID <= 1'b0;
      div_start     <= 1'b0;
      // A change in any state abandons the current calculation and restarts it.
      if (force_start || changed) begin
        sh_width    <= bus.HDMI_WIDTH;
        sh_height   <= bus.HDMI_HEIGHT;
        sh_arx      <= bus.VIDEO_ARX;
        sh_ary      <= bus.VIDEO_ARY;
        force_start <= 1'b0;
        bus.BUSY    <= 1'b1;
        state       <= entry_state;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          MUL1: begin
            div_start <= 1'b1;
            state     <= DIV1;
          end
          // DONE seen in the START cycle belongs to an abandoned run.
          DIV1:  if (!div_start && div_done) state <= CHECK;
          CHECK: state <= fits ? PLACE : MUL2;
          MUL2: begin
            div_start <= 1'b1;
            state     <= DIV2;
          end
          DIV2:  if (!div_start && div_done) state <= PLACE;
          SIZE:  state <= PLACE;
          PLACE: state <= COMMIT;
          COMMIT: begin
            bus.HMIN      <= hmin_n;
            bus.HMAX      <= hmax_n;
            bus.VMIN      <= vmin_n;
            bus.VMAX      <= vmax_n;
            bus.WIN_VALID <= 1'b1;
            bus.BUSY      <= 1'b0;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    case (state)
      MUL1:  prod <= DIV_W'(sh_height) * DIV_W'(sh_arx[COORD_W-1:0]);
      MUL2:  prod <= DIV_W'(sh_width) * DIV_W'(sh_ary[COORD_W-1:0]);
      CHECK: begin
        if (fits) begin
          w <= sat_min1(quo[COORD_W-1:0]);
          h <= sat_min1(sh_height);
        end
      end
      DIV2: begin
        w <= sat_min1(sh_width);
        h <= sat_min1(quo[COORD_W-1:0]);
      end
      SIZE: begin
        if (sh_arx[ABS_FLAG] && sh_ary[ABS_FLAG]) begin
          w <= sat_min1(abs_size(sh_arx[COORD_W-1:0], sh_width));
          h <= sat_min1(abs_size(sh_ary[COORD_W-1:0], sh_height));
        end else begin
          w <= sat_min1(sh_width);
          h <= sat_min1(sh_height);
        end
      end
      PLACE: begin
        hmin_n <= hmin_c;
        hmax_n <= hmin_c + w - 1'b1;
        vmin_n <= vmin_c;
        vmax_n <= vmin_c + h - 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_video_ar_window.sv
// Directed bench for video_ar_window: vector table plus abort and mid-run reset sequences.
module tb_video_ar_window;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  video_ar_window_if bus ();

  video_ar_window #(.DIV_W(24)) dut (
    .CLK_VIDEO (clk),
    .RESET_N   (rst_n),
    .bus       (bus)
  );

  typedef struct {
    int width;
    int height;
    int arx;
    int ary;
    int hmin;
    int hmax;
    int vmin;
    int vmax;
    int cyc;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input int wd, input int ht, input int ax, input int ay);
    bus.HDMI_WIDTH  = 12'(wd);
    bus.HDMI_HEIGHT = 12'(ht);
    bus.VIDEO_ARX   = 13'(ax);
    bus.VIDEO_ARY   = 13'(ay);
  endtask

  // Counts from the edge after the drive (cycle 0); -1 means WIN_VALID never came.
  task automatic wait_win(input int limit, output int cyc, output int busy1, output int stable);
    logic [47:0] prev;
    bit          got;
    prev   = {bus.HMIN, bus.HMAX, bus.VMIN, bus.VMAX};
    cyc    = 0;
    got    = 1'b0;
    busy1  = 0;
    stable = 1;
    while (!got && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy1 = int'(bus.BUSY);
      if (bus.WIN_VALID) got = 1'b1;
      else if ({bus.HMIN, bus.HMAX, bus.VMIN, bus.VMAX} != prev) stable = 0;
    end
    if (!got) cyc = -1;
  endtask

  task automatic check_window(input string tag, input int hmin, input int hmax,
                              input int vmin, input int vmax);
    check({tag, "_hmin"}, int'(bus.HMIN), hmin);
    check({tag, "_hmax"}, int'(bus.HMAX), hmax);
    check({tag, "_vmin"}, int'(bus.VMIN), vmin);
    check({tag, "_vmax"}, int'(bus.VMAX), vmax);
  endtask

  task automatic check_after(input string tag);
    @(negedge clk);
    check({tag, "_pulse_width"}, int'(bus.WIN_VALID), 0);
    check({tag, "_busy_clear"}, int'(bus.BUSY), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int    cyc;
    int    busy1;
    int    stable;
    int    pulses;
    int    wcyc;
    string tag;

    //            W     H     ARX     ARY     HMIN HMAX  VMIN VMAX  CYC
    vecs[0]  = '{1920, 1080, 21,     9,      0,   1919, 129, 950,  56};
    vecs[1]  = '{1920, 1080, 'h1500, 'h13C0, 320, 1599, 60,  1019, 4};
    vecs[2]  = '{1920, 1080, 4,      0,      0,   1919, 0,   1079, 4};
    vecs[3]  = '{1920, 1080, 'h1500, 3,      0,   1919, 0,   1079, 4};
    vecs[4]  = '{1920, 1080, 16,     9,      0,   1919, 0,   1079, 30};
    vecs[5]  = '{1920, 1080, 32,     18,     0,   1919, 0,   1079, 30};
    vecs[6]  = '{1920, 1080, 'h1FFF, 'h1200, 0,   1919, 284, 795,  4};
    vecs[7]  = '{1920, 1080, 'h1000, 'h1100, 0,   1919, 412, 667,  4};
    vecs[8]  = '{1920, 1080, 1,      4095,   959, 959,  0,   1079, 30};
    vecs[9]  = '{1280, 720,  4,      3,      160, 1119, 0,   719,  30};
    vecs[10] = '{1280, 720,  4095,   1,      0,   1279, 359, 359,  56};
    vecs[11] = '{1920, 1080, 9,      16,     656, 1262, 0,   1079, 30};

    rst_n = 1'b0;
    drive(1920, 1080, 4, 3);
    repeat (3) @(negedge clk);
    check_window("reset", 0, 0, 0, 0);
    check("reset_win_valid", int'(bus.WIN_VALID), 0);
    check("reset_busy", int'(bus.BUSY), 0);

    // Forced calculation straight after release
    rst_n = 1'b1;
    wait_win(200, cyc, busy1, stable);
    check("forced_cycle", cyc, 30);
    check("forced_busy", busy1, 1);
    check_window("forced", 240, 1679, 0, 1079);
    check_after("forced");

    for (int i = 0; i < NV; i++) begin
      tag = $sformatf("v%0d", i);
      drive(vecs[i].width, vecs[i].height, vecs[i].arx, vecs[i].ary);
      wait_win(200, cyc, busy1, stable);
      check({tag, "_cycle"}, cyc, vecs[i].cyc);
      check({tag, "_busy"}, busy1, 1);
      check({tag, "_stable"}, stable, 1);
      check_window(tag, vecs[i].hmin, vecs[i].hmax, vecs[i].vmin, vecs[i].vmax);
      check_after(tag);
    end

    // Two restarts during DIV1; only the final 16:9 set may commit
    drive(1920, 1080, 4, 3);
    pulses = 0;
    wcyc   = -1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (bus.WIN_VALID) begin
        pulses++;
        wcyc = c;
      end
      if (c == 10) bus.VIDEO_ARX = 13'd16;
      if (c == 15) bus.VIDEO_ARY = 13'd9;
    end
    check("abort_pulses", pulses, 1);
    check("abort_cycle", wcyc, 45);
    check_window("abort", 0, 1919, 0, 1079);

    // Reset in the middle of DIV2
    drive(1920, 1080, 21, 9);
    repeat (40) @(negedge clk);
    check("div2_busy", int'(bus.BUSY), 1);
    rst_n = 1'b0;
    #1;
    check_window("midreset", 0, 0, 0, 0);
    check("midreset_busy", int'(bus.BUSY), 0);
    check("midreset_win_valid", int'(bus.WIN_VALID), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_win(200, cyc, busy1, stable);
    check("recover_cycle", cyc, 56);
    check_window("recover", 0, 1919, 129, 950);
    check_after("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
